// File: rtl/apb_ctrl_pkg.sv
// Shared state encoding, default widths and index-width helper for the APB master arbiter.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_OWNER_W = owner_w(DEF_NUM_REQ);

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick: searches from the requester after the last winner; pointer moves on grant_en.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = owner_w(NUM_REQ)
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int cand;
    cand      = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!any_valid && valid[IDX_W'(cand)]) begin
        any_valid                  = 1'b1;
        grant_oh[IDX_W'(cand)]     = 1'b1;
        grant_idx                  = IDX_W'(cand);
      end
    end
  end

  // Reset pointer to the last requester so requester 0 wins first.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (grant_en) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master controller sharing one slave port among NUM_REQ requesters (round-robin).
// Define APB_TIMEOUT_EN to end ACCESS with an error after TIMEOUT_CYCLES without PREADY.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int IDLE_CYCLES    = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PSLVERR
);
  // state  | meaning
  // IDLE   | PSEL low; arbitrate once the idle counter has expired
  // SETUP  | PSEL=1, PENABLE=0; address/control already latched
  // ACCESS | PSEL=1, PENABLE=1; wait for PREADY (or timeout)

  localparam int IDX_W = owner_w(NUM_REQ);
  localparam int IC_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDLE_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_arbiter: unsupported parameter set");
  end

  apb_state_e       state, next_state;
  logic [IC_W-1:0]  idle_cnt;
  logic [IDX_W-1:0] owner;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             any_win;
  logic             arb_en;
  logic             grant;
  logic             done;
  logic             timeout;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .valid     (req_valid),
    .grant_en  (grant),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .any_valid (any_win)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt;

  // Loaded in SETUP so it reads zero on the TIMEOUT_CYCLES-th ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (state == ACCESS && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !PREADY && (wait_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  assign done      = (state == ACCESS) && (PREADY || timeout);
  assign grant     = arb_en && any_win;
  assign req_ready = grant ? win_oh : '0;
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    arb_en     = 1'b0;
    case (state)
      IDLE: begin
        arb_en = (idle_cnt == '0);
        if (arb_en && any_win) next_state = SETUP;
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        if (done) begin
          if (IDLE_CYCLES == 0) begin
            arb_en     = 1'b1;
            next_state = any_win ? SETUP : IDLE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      owner     <= '0;
      idle_cnt  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err          <= PSLVERR || timeout;
        if (!PWRITE && !timeout) rsp_rdata <= PRDATA;
      end
      if (grant) begin
        PADDR  <= addr_arr[win_idx];
        PWDATA <= wdata_arr[win_idx];
        PWRITE <= req_write[win_idx];
        owner  <= win_idx;
      end
      if (done && IDLE_CYCLES > 0) begin
        idle_cnt <= IC_W'(IDLE_CYCLES - 1);
      end else if (state == IDLE && idle_cnt != '0) begin
        idle_cnt <= idle_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: back-to-back instance plus an IDLE_CYCLES=2 instance.
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESETn;

  logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  logic [3:0]  ic_req_valid, ic_req_write, ic_req_ready, ic_rsp_valid;
  logic [31:0] ic_req_addr;
  logic [127:0] ic_req_wdata;
  logic [31:0] ic_rsp_rdata;
  logic        ic_rsp_err, ic_psel, ic_penable, ic_pwrite, ic_pready, ic_pslverr;
  logic [7:0]  ic_paddr;
  logic [31:0] ic_pwdata, ic_prdata;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .IDLE_CYCLES(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .IDLE_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut_ic (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(ic_req_valid), .req_write(ic_req_write), .req_addr(ic_req_addr),
    .req_wdata(ic_req_wdata), .req_ready(ic_req_ready), .rsp_valid(ic_rsp_valid),
    .rsp_rdata(ic_rsp_rdata), .rsp_err(ic_rsp_err),
    .PSEL(ic_psel), .PENABLE(ic_penable), .PWRITE(ic_pwrite), .PADDR(ic_paddr),
    .PWDATA(ic_pwdata), .PREADY(ic_pready), .PRDATA(ic_prdata), .PSLVERR(ic_pslverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_rr [5];
    int         exp_idx [5];
    int         n;
    int         lowc;

    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_idx = '{0, 1, 2, 3, 0};

    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
    ic_req_valid = '0; ic_req_write = '0; ic_req_addr = '0; ic_req_wdata = '0;
    ic_pready = 1'b1; ic_prdata = '0; ic_pslverr = 1'b0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ic_psel", ic_psel, 0);
    PRESETn = 1'b1;
    step();

    // Requester 0 write, zero wait states
    req_valid = 4'b0001; req_write = 4'b0001;
    req_addr[0 +: 8] = 8'h10; req_wdata[0 +: 32] = 32'hA5;
    #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    chk("t1_psel_idle", PSEL, 0);
    step();
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_penable", PENABLE, 0);
    chk("t1_paddr", PADDR, 8'h10);
    chk("t1_pwdata", PWDATA, 32'hA5);
    chk("t1_pwrite", PWRITE, 1);
    req_valid = '0;
    step();
    chk("t1_access_psel", PSEL, 1);
    chk("t1_access_penable", PENABLE, 1);
    chk("t1_no_early_rsp", rsp_valid, 0);
    step();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_psel_drop", PSEL, 0);
    step();
    chk("t1_rsp_pulse", rsp_valid, 0);

    // Requester 2 read with two wait states
    PREADY = 1'b0;
    req_valid = 4'b0100; req_write = 4'b0000; req_addr[16 +: 8] = 8'h24;
    #1;
    chk("t2_req_ready", req_ready, 4'b0100);
    step();
    chk("t2_paddr", PADDR, 8'h24);
    chk("t2_pwrite", PWRITE, 0);
    req_valid = '0;
    step();
    chk("t2_access1", PENABLE, 1);
    step();
    chk("t2_access2", PENABLE, 1);
    chk("t2_no_rsp", rsp_valid, 0);
    step();
    chk("t2_access3", PENABLE, 1);
    PREADY = 1'b1; PRDATA = 32'h5A5A5A5A;
    step();
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_rdata", rsp_rdata, 32'h5A5A5A5A);
    chk("t2_rsp_err", rsp_err, 0);
    chk("t2_psel_drop", PSEL, 0);
    chk("t2_paddr_hold", PADDR, 8'h24);

    // Requester 1 write completing with PSLVERR
    PRDATA = 32'hDEADBEEF; PSLVERR = 1'b1;
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[8 +: 8] = 8'h31; req_wdata[32 +: 32] = 32'h1234;
    #1;
    chk("t3_req_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    chk("t3_pwdata", PWDATA, 32'h1234);
    step();
    step();
    chk("t3_rsp_valid", rsp_valid, 4'b0010);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_rdata_write", rsp_rdata, 0);
    PSLVERR = 1'b0; PRDATA = '0;

    // Requester 3 read, reset pulsed during ACCESS
    PREADY = 1'b0;
    req_valid = 4'b1000; req_write = 4'b0000; req_addr[24 +: 8] = 8'h3C;
    #1;
    chk("t4_req_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    step();
    chk("t4_in_access", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t4_async_psel", PSEL, 0);
    chk("t4_async_penable", PENABLE, 0);
    step();
    PREADY = 1'b1;
    PRESETn = 1'b1;
    step();
    chk("t4_no_rsp1", rsp_valid, 0);
    step();
    chk("t4_no_rsp2", rsp_valid, 0);
    chk("t4_psel_idle", PSEL, 0);

    // All requesters held valid: round-robin order, back-to-back transfers
    req_write = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*8 +: 8]    = 8'h40 + 8'(i);
      req_wdata[i*32 +: 32] = 32'h100 + 32'(i);
    end
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == 4'b0000 && n < 10) begin
        step();
        n++;
      end
      chk("rr_grant", req_ready, exp_rr[k]);
      step();
      chk("rr_setup_psel", PSEL, 1);
      chk("rr_setup_penable", PENABLE, 0);
      chk("rr_paddr", PADDR, 8'h40 + 8'(exp_idx[k]));
      if (k > 0) chk("rr_prev_rsp", rsp_valid, exp_rr[k-1]);
      step();
      chk("rr_access_penable", PENABLE, 1);
    end
    req_valid = '0;
    #1;
    chk("rr_no_grant_after_drop", req_ready, 0);
    step();
    chk("rr_last_rsp", rsp_valid, 4'b0001);
    chk("rr_psel_drop", PSEL, 0);
    step();
    chk("rr_rsp_pulse", rsp_valid, 0);

    // IDLE_CYCLES=2 instance: two queued writes separated by two PSEL-low cycles
    ic_req_write = 4'b0011;
    ic_req_addr[0 +: 8] = 8'h50; ic_req_addr[8 +: 8] = 8'h51;
    ic_req_wdata[0 +: 32] = 32'hAA; ic_req_wdata[32 +: 32] = 32'hBB;
    ic_req_valid = 4'b0011;
    #1;
    chk("ic_first_grant", ic_req_ready, 4'b0001);
    step();
    chk("ic_setup_psel", ic_psel, 1);
    chk("ic_paddr0", ic_paddr, 8'h50);
    ic_req_valid = 4'b0010;
    step();
    chk("ic_access", ic_penable, 1);
    lowc = 0;
    step();
    while (ic_psel == 1'b0 && lowc < 10) begin
      lowc++;
      step();
    end
    chk("ic_psel_low_cycles", lowc, 2);
    chk("ic_paddr1", ic_paddr, 8'h51);
    chk("ic_pwdata1", ic_pwdata, 32'hBB);
    ic_req_valid = '0;
    step();
    step();
    chk("ic_rsp_valid1", ic_rsp_valid, 4'b0010);

`ifdef APB_TIMEOUT_EN
    // PREADY never arrives: transfer ends with an error after 16 ACCESS cycles
    PREADY = 1'b0; PRDATA = 32'hCAFEF00D;
    req_valid = 4'b0001; req_write = 4'b0000;
    #1;
    chk("to_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    n = 0;
    while (rsp_valid == 4'b0000 && n < 40) begin
      if (PENABLE) n++;
      step();
    end
    chk("to_access_cycles", n, 16);
    chk("to_rsp_valid", rsp_valid, 4'b0001);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel_drop", PSEL, 0);
    PREADY = 1'b1;
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
